// File: rtl/sd_cmd_ctrl_if.sv
// Host-side command request and SD bus pins of the command controller.
interface sd_cmd_ctrl_if;
    logic        start;
    logic        fast_mode;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        busy;
    logic        done;
    logic        sd_clk;
    logic        sd_cmd;
    logic        sd_cmd_oe;

    // Requester side: issues commands and observes the bus.
    modport master (
        output start, fast_mode, cmd_index, cmd_arg,
        input  busy, done, sd_clk, sd_cmd, sd_cmd_oe
    );

    // Controller side: accepts commands and drives the bus.
    modport slave (
        input  start, fast_mode, cmd_index, cmd_arg,
        output busy, done, sd_clk, sd_cmd, sd_cmd_oe
    );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// SD command-line sequencer: power-up clock train, then one 48-bit CRC7 frame per
// accepted command followed by 8 trailing clocks, all on a gated divided sd_clk.
module sd_cmd_ctrl #(
    parameter int unsigned DIV_SLOW  = 500,
    parameter int unsigned DIV_FAST  = 2,
    parameter int unsigned INIT_CLKS = 80
) (
    input  logic          clk,
    input  logic          reset_n,
    sd_cmd_ctrl_if.slave  bus
);

    localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int unsigned CW      = $clog2(DIV_MAX + 1);
    localparam int unsigned EW_INIT = $clog2(INIT_CLKS + 1);
    localparam int unsigned EW      = (EW_INIT > 6) ? EW_INIT : 6;

    // Divider limits are stored as D-1 so the compare needs no subtractor.
    localparam logic [CW-1:0] SLOW_M1   = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0] FAST_M1   = CW'(DIV_FAST - 1);
    localparam logic [EW-1:0] INIT_LAST = EW'(INIT_CLKS - 1);
    localparam logic [EW-1:0] SEND_LAST = EW'(47);
    localparam logic [EW-1:0] NCC_LAST  = EW'(7);

    typedef enum logic [1:0] {StInit, StIdle, StSend, StNcc} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_m1_q, div_m1_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [47:0]   shreg_q, shreg_d;
    logic          sd_clk_q, sd_clk_d;
    logic          done_q, done_d;

    logic [39:0]   hdr;
    logic [47:0]   frame;
    logic [CW-1:0] div_top;
    logic          tick;
    logic          fall;

    // CRC7, polynomial x^7 + x^3 + 1, zero seed, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    assign hdr     = {2'b01, bus.cmd_index, bus.cmd_arg};
    assign frame   = {hdr, crc7(hdr), 1'b1};
    assign div_top = (state_q == StInit) ? SLOW_M1 : div_m1_q;
    assign tick    = (cnt_q == div_top);
    // Frame bits and edge counts advance on sd_clk falling edges only.
    assign fall    = tick & sd_clk_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            div_m1_q <= '0;
            edge_q   <= '0;
            shreg_q  <= '0;
            sd_clk_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_m1_q <= div_m1_d;
            edge_q   <= edge_d;
            shreg_q  <= shreg_d;
            sd_clk_q <= sd_clk_d;
            done_q   <= done_d;
        end
    end

    // Next-state: divider, edge counting, frame shifting and command acceptance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_m1_d = div_m1_q;
        edge_d   = edge_q;
        shreg_d  = shreg_q;
        sd_clk_d = sd_clk_q;
        done_d   = 1'b0;

        if (state_q != StIdle) begin
            if (tick) begin
                cnt_d    = '0;
                sd_clk_d = ~sd_clk_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        unique case (state_q)
            StInit: begin
                if (fall) begin
                    if (edge_q == INIT_LAST) begin
                        edge_d  = '0;
                        state_d = StIdle;
                    end else begin
                        edge_d = edge_q + EW'(1);
                    end
                end
            end
            StIdle: begin
                cnt_d    = '0;
                sd_clk_d = 1'b0;
                if (bus.start) begin
                    div_m1_d = bus.fast_mode ? FAST_M1 : SLOW_M1;
                    shreg_d  = frame;
                    edge_d   = '0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (fall) begin
                    if (edge_q == SEND_LAST) begin
                        edge_d  = '0;
                        state_d = StNcc;
                    end else begin
                        edge_d  = edge_q + EW'(1);
                        shreg_d = {shreg_q[46:0], 1'b1};
                    end
                end
            end
            StNcc: begin
                if (fall) begin
                    if (edge_q == NCC_LAST) begin
                        edge_d  = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        edge_d = edge_q + EW'(1);
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Outputs decoded from registered state so reset forces them immediately.
    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.done      = done_q;
        bus.sd_clk    = sd_clk_q;
        bus.sd_cmd_oe = (state_q == StSend);
        bus.sd_cmd    = (state_q == StSend) ? shreg_q[47] : 1'b1;
    end

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: init train, fast/slow frames, ignored inputs,
// back-to-back commands and reset abort.
module tb_sd_cmd_ctrl;

    localparam int DS = 10;
    localparam int DF = 2;
    localparam int IC = 80;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sd_cmd_ctrl_if bus ();

    sd_cmd_ctrl #(
        .DIV_SLOW  (DS),
        .DIV_FAST  (DF),
        .INIT_CLKS (IC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Runs from a reset release at a negedge until busy falls, collecting init stats.
    task automatic init_train(input bit drop_start, output int cyc, output int rises,
                              output int bad_line, output int bad_per, output int dones);
        int   last_rise;
        logic prev;
        cyc = 0; rises = 0; bad_line = 0; bad_per = 0; dones = 0;
        last_rise = -1; prev = 1'b0;
        while (bus.busy === 1'b1 && cyc < 2 * IC * DS + 100) begin
            @(negedge clk);
            cyc++;
            if (drop_start && cyc == 2 * IC * DS - 5) bus.start = 1'b0;
            if (bus.sd_cmd !== 1'b1 || bus.sd_cmd_oe !== 1'b0) bad_line++;
            if (bus.done !== 1'b0) dones++;
            if (bus.sd_clk === 1'b1 && prev === 1'b0) begin
                rises++;
                if (last_rise >= 0 && cyc - last_rise != 2 * DS) bad_per++;
                last_rise = cyc;
            end
            prev = bus.sd_clk;
        end
    endtask

    // Called right after the acceptance edge (cycle 0); returns at the done cycle.
    task automatic capture(input int d, input bit hold, input bit disturb,
                           input logic [5:0] nidx, input logic [31:0] narg,
                           output logic [47:0] frame, output int done_cyc,
                           output int oe_fall, output int first_rise,
                           output int send_rises, output int ncc_rises,
                           output int bad_hp, output bit c1_ok);
        logic prev_clk, prev_oe;
        int   last_tog, c;
        bit   fin;
        frame = '0; done_cyc = -1; oe_fall = -1; first_rise = -1;
        send_rises = 0; ncc_rises = 0; bad_hp = 0; c1_ok = 1'b0;
        prev_clk = 1'b0; prev_oe = 1'b0; last_tog = 1; c = 0; fin = 1'b0;
        while (!fin && c < 1 + 112 * d + 50) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                c1_ok = (bus.busy === 1'b1 && bus.sd_cmd_oe === 1'b1 &&
                         bus.sd_cmd === 1'b0 && bus.sd_clk === 1'b0);
                if (hold) begin
                    bus.cmd_index = nidx;
                    bus.cmd_arg   = narg;
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (disturb && c == 40) begin
                bus.start     = 1'b1;
                bus.cmd_index = ~bus.cmd_index;
                bus.cmd_arg   = ~bus.cmd_arg;
                bus.fast_mode = ~bus.fast_mode;
            end
            if (disturb && c == 41) bus.start = 1'b0;
            if (prev_oe === 1'b1 && bus.sd_cmd_oe === 1'b0 && oe_fall < 0) oe_fall = c;
            if (bus.sd_clk !== prev_clk) begin
                if (c - last_tog != d) bad_hp++;
                last_tog = c;
                if (bus.sd_clk === 1'b1) begin
                    if (first_rise < 0) first_rise = c;
                    if (bus.sd_cmd_oe === 1'b1) begin
                        frame = {frame[46:0], bus.sd_cmd};
                        send_rises++;
                    end else begin
                        ncc_rises++;
                    end
                end
            end
            prev_clk = bus.sd_clk;
            prev_oe  = bus.sd_cmd_oe;
            if (bus.done === 1'b1) begin
                done_cyc = c;
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int cyc, rises, bad_line, bad_per, dones, idle_bad;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.fast_mode = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.sd_clk, bus.sd_cmd, bus.sd_cmd_oe} !== 5'b10010) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 10010",
                     {bus.busy, bus.done, bus.sd_clk, bus.sd_cmd, bus.sd_cmd_oe});
        end
        // start held through most of INIT must not launch a frame.
        bus.start = 1'b1; bus.cmd_index = 6'd8; bus.cmd_arg = 32'h1AA;
        reset_n = 1'b1;
        init_train(1'b1, cyc, rises, bad_line, bad_per, dones);
        n_cmp++;
        if (cyc !== 2 * IC * DS) begin
            n_err++; $display("FAIL init_length: got %0d expected %0d", cyc, 2 * IC * DS);
        end
        n_cmp++;
        if (rises !== IC) begin
            n_err++; $display("FAIL init_clocks: got %0d expected %0d", rises, IC);
        end
        n_cmp++;
        if (bad_line !== 0 || bad_per !== 0) begin
            n_err++; $display("FAIL init_line_period: got %0d/%0d expected 0/0",
                              bad_line, bad_per);
        end
        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.sd_clk !== 1'b0 || bus.sd_cmd_oe !== 1'b0) idle_bad++;
        end
        n_cmp++;
        if (idle_bad !== 0) begin
            n_err++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", idle_bad);
        end
    endtask

    task automatic test_cmd0_fast();
        logic [47:0] fr;
        int dc, of, fr1, sr, nr, hp;
        bit c1;
        @(negedge clk);
        bus.start = 1'b1; bus.fast_mode = 1'b1; bus.cmd_index = 6'd0; bus.cmd_arg = 32'h0;
        @(posedge clk);
        capture(DF, 1'b0, 1'b0, 6'd0, 32'h0, fr, dc, of, fr1, sr, nr, hp, c1);
        n_cmp++;
        if (fr !== 48'h400000000095) begin
            n_err++; $display("FAIL cmd0_frame: got %012h expected 400000000095", fr);
        end
        n_cmp++;
        if (dc !== 225) begin
            n_err++; $display("FAIL cmd0_done_cycle: got %0d expected 225", dc);
        end
        n_cmp++;
        if (of !== 1 + 96 * DF || nr !== 8 || sr !== 48) begin
            n_err++; $display("FAIL cmd0_oe_ncc: got oe_fall %0d ncc %0d send %0d expected %0d 8 48",
                              of, nr, sr, 1 + 96 * DF);
        end
        n_cmp++;
        if (!c1 || fr1 !== 1 + DF || hp !== 0) begin
            n_err++; $display("FAIL cmd0_timing: got c1 %0d rise %0d hp %0d expected 1 %0d 0",
                              c1, fr1, hp, 1 + DF);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sd_clk !== 1'b0) begin
            n_err++; $display("FAIL cmd0_done_width: got done %b busy %b clk %b expected 0 0 0",
                              bus.done, bus.busy, bus.sd_clk);
        end
    endtask

    task automatic test_cmd8_slow();
        logic [47:0] fr;
        int dc, of, fr1, sr, nr, hp;
        bit c1;
        @(negedge clk);
        bus.start = 1'b1; bus.fast_mode = 1'b0; bus.cmd_index = 6'd8; bus.cmd_arg = 32'h1AA;
        @(posedge clk);
        capture(DS, 1'b0, 1'b0, 6'd0, 32'h0, fr, dc, of, fr1, sr, nr, hp, c1);
        n_cmp++;
        if (fr !== 48'h48000001AA87) begin
            n_err++; $display("FAIL cmd8_frame: got %012h expected 48000001aa87", fr);
        end
        n_cmp++;
        if (dc !== 1 + 112 * DS) begin
            n_err++; $display("FAIL cmd8_done_cycle: got %0d expected %0d", dc, 1 + 112 * DS);
        end
        n_cmp++;
        if (hp !== 0 || fr1 !== 1 + DS) begin
            n_err++; $display("FAIL cmd8_half_period: got hp %0d rise %0d expected 0 %0d",
                              hp, fr1, 1 + DS);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++; $display("FAIL cmd8_done_width: got %b expected 0", bus.done);
        end
    endtask

    task automatic test_ignore_inputs();
        logic [47:0] fr;
        int dc, of, fr1, sr, nr, hp, extra;
        bit c1;
        @(negedge clk);
        bus.start = 1'b1; bus.fast_mode = 1'b1; bus.cmd_index = 6'd0; bus.cmd_arg = 32'h0;
        @(posedge clk);
        capture(DF, 1'b0, 1'b1, 6'd0, 32'h0, fr, dc, of, fr1, sr, nr, hp, c1);
        n_cmp++;
        if (fr !== 48'h400000000095) begin
            n_err++; $display("FAIL ignore_frame: got %012h expected 400000000095", fr);
        end
        n_cmp++;
        if (dc !== 225 || hp !== 0) begin
            n_err++; $display("FAIL ignore_timing: got done %0d hp %0d expected 225 0", dc, hp);
        end
        extra = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sd_cmd_oe !== 1'b0) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++; $display("FAIL ignore_single_done: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] fr;
        int dc, of, fr1, sr, nr, hp;
        bit c1;
        @(negedge clk);
        bus.start = 1'b1; bus.fast_mode = 1'b1; bus.cmd_index = 6'd55; bus.cmd_arg = 32'h0;
        @(posedge clk);
        // Inputs switch to CMD0 after acceptance; start stays high.
        capture(DF, 1'b1, 1'b0, 6'd0, 32'h0, fr, dc, of, fr1, sr, nr, hp, c1);
        n_cmp++;
        if (fr !== 48'h770000000065 || dc !== 225) begin
            n_err++; $display("FAIL b2b_first: got %012h at %0d expected 770000000065 at 225",
                              fr, dc);
        end
        capture(DF, 1'b0, 1'b0, 6'd0, 32'h0, fr, dc, of, fr1, sr, nr, hp, c1);
        n_cmp++;
        if (!c1) begin
            n_err++; $display("FAIL b2b_start_bit: got c1 %0d expected 1", c1);
        end
        n_cmp++;
        if (fr1 !== 1 + DF || hp !== 0) begin
            n_err++; $display("FAIL b2b_no_extra_clk: got rise %0d hp %0d expected %0d 0",
                              fr1, hp, 1 + DF);
        end
        n_cmp++;
        if (fr !== 48'h400000000095 || dc !== 225) begin
            n_err++; $display("FAIL b2b_second: got %012h at %0d expected 400000000095 at 225",
                              fr, dc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int cyc, rises, bad_line, bad_per, dones;
        @(negedge clk);
        bus.start = 1'b1; bus.fast_mode = 1'b1; bus.cmd_index = 6'd0; bus.cmd_arg = 32'h0;
        @(posedge clk);
        // Bit 20 is on the line from cycle 109 to 112 at D=2.
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        n_cmp++;
        if (bus.sd_cmd_oe !== 1'b1) begin
            n_err++; $display("FAIL abort_in_frame: got oe %b expected 1", bus.sd_cmd_oe);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.sd_clk, bus.sd_cmd, bus.sd_cmd_oe} !== 5'b10010) begin
            n_err++; $display("FAIL abort_async: got %b expected 10010",
                              {bus.busy, bus.done, bus.sd_clk, bus.sd_cmd, bus.sd_cmd_oe});
        end
        @(negedge clk);
        reset_n = 1'b1;
        init_train(1'b0, cyc, rises, bad_line, bad_per, dones);
        n_cmp++;
        if (cyc !== 2 * IC * DS || rises !== IC) begin
            n_err++; $display("FAIL abort_reinit: got %0d cycles %0d clocks expected %0d %0d",
                              cyc, rises, 2 * IC * DS, IC);
        end
        n_cmp++;
        if (dones !== 0 || bad_line !== 0) begin
            n_err++; $display("FAIL abort_no_done: got done %0d line %0d expected 0 0",
                              dones, bad_line);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0_fast();
        test_cmd8_slow();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_ctrl.md
# sd_cmd_ctrl

Sequences the SD bus clock and command line for the SD card interface. After reset it generates the card power-up clock train. It then accepts one command at a time: it builds the 48-bit frame with CRC7, shifts the frame out on `sd_cmd` against a divided `sd_clk`, and adds the trailing Ncc clocks. This block replaces the free-running fixed-rate SD clock with a gated, rate-selectable clock owned by the command path. Response reception is out of scope and belongs to a separate block.

## Interface
- `DIV_SLOW`, default 500: `sd_clk` half-period in `clk` cycles for init/identification rate; must be ≥1.
- `DIV_FAST`, default 2: `sd_clk` half-period in `clk` cycles for data-transfer rate; must be ≥1.
- `INIT_CLKS`, default 80: number of full `sd_clk` periods emitted after reset with `sd_cmd` high; must be ≥74.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `fast_mode`  in  1  selects `DIV_FAST` (1) or `DIV_SLOW` (0); sampled only when `start` is accepted.
- `start`  in  1  command request; accepted only in IDLE (`busy`=0); ignored otherwise.
- `cmd_index`  in  6  command index; sampled on acceptance.
- `cmd_arg`  in  32  command argument; sampled on acceptance.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `sd_clk`  out  1  SD bus clock; held low when gated.
- `sd_cmd`  out  1  command line data; 1 when not driving a frame bit.
- `sd_cmd_oe`  out  1  command line output enable.

## Operation
- States: INIT, IDLE, SEND, NCC.
- Reset values: state INIT, `busy`=1, `done`=0, `sd_clk`=0, `sd_cmd`=1, `sd_cmd_oe`=0, all counters 0.
- Divider: a half-period counter runs only in INIT, SEND and NCC. When the counter reaches D−1, it returns to 0 and `sd_clk` toggles. D is `DIV_SLOW` in INIT; otherwise D is the value latched at acceptance.
- INIT: emits `INIT_CLKS` full periods at `DIV_SLOW`, with `sd_cmd`=1 and `sd_cmd_oe`=0. After the falling edge of the last period it goes to IDLE with `sd_clk`=0. `start` is ignored in INIT.
- IDLE: `sd_clk` held 0 and divider held 0. `start`=1 latches `fast_mode`, `cmd_index` and `cmd_arg`, and goes to SEND.
- Frame construction, bits 47..0:
  - bit 47: 0 (start bit)
  - bit 46: 1 (transmission bit)
  - bits 45:40: `cmd_index`
  - bits 39:8: `cmd_arg`
  - bits 7:1: CRC7 over bits 47:8, polynomial x^7+x^3+1, initial value 0
  - bit 0: 1 (end bit)
- CRC7 is computed in the acceptance cycle, combinationally or by any method that produces the bit in time.
- SEND: `sd_cmd_oe`=1 and `sd_cmd` presents the current frame bit, MSB first. The bit changes only when `sd_clk` falls, so it is stable across each rising edge. After 48 rising edges, the falling edge that follows goes to NCC with `sd_cmd_oe`=0 and `sd_cmd`=1.
- NCC: 8 more full periods with the line released. On the 8th falling edge: `done`=1 for one cycle, `busy`=0, state IDLE. `sd_clk` stays low from that cycle on.
- Asynchronous reset at any time: all outputs take their reset values immediately, any frame in progress is abandoned, and the INIT train runs again.
- Input changes while `busy`=1 have no effect.

## Timing
- The cycle in which `start` is sampled high in IDLE is cycle 0.
- Cycle 1: `busy`=1, `sd_cmd_oe`=1, `sd_cmd`=0 (start bit), `sd_clk`=0.
- Rising edges of `sd_clk` occur at cycles 1+D+2kD; falling edges at 1+2D+2kD, for k=0..55.
- Frame bit n (47 down to 0) is valid from cycle 1+2(47−n)D until cycle 1+2(48−n)D.
- `sd_cmd_oe` falls at cycle 1+96D.
- `done`=1 and `busy`=0 at cycle 1+112D. A new `start` is accepted in that same cycle.
- Examples: D=2 gives `done` at cycle 225; D=500 gives `done` at cycle 56001.
- INIT duration after `reset_n` rises: `2·INIT_CLKS·DIV_SLOW` cycles. The default is 80000; `busy` falls on the last of these cycles.

## Test plan
- Reset release with defaults:
  - exactly 80 `sd_clk` periods of 1000 cycles each, `sd_cmd`=1, `sd_cmd_oe`=0 throughout
  - then `busy`=0 with `sd_clk` held low for 1000 idle cycles
- CMD0, `cmd_arg`=0x00000000, `fast_mode`=1:
  - bits sampled on `sd_clk` rising edges equal 0x400000000095 (CRC 0x4A)
  - `done` at cycle 225, single cycle
  - 8 trailing clocks with `sd_cmd_oe`=0
- CMD8, `cmd_arg`=0x000001AA, `fast_mode`=0:
  - captured frame 0x48000001AA87 (CRC 0x43)
  - `sd_clk` half-period 500 cycles
  - `done` at cycle 56001
- `start` pulsed during INIT and during SEND, with `cmd_index`/`cmd_arg`/`fast_mode` toggled mid-frame:
  - no new frame and no corruption of the frame in progress
  - exactly one `done`
- Back-to-back: `start` held high continuously:
  - second frame's start bit appears at the cycle after `done`
  - no extra idle clock pulse between frames
- `reset_n` asserted at frame bit 20:
  - `sd_cmd_oe`=0, `sd_cmd`=1, `sd_clk`=0, `busy`=1 asynchronously
  - full INIT train repeats and no `done` is produced for the aborted frame
